// File: rtl/tensor_uart_dumper_pkg.sv
// Shared types and constants for the tensor UART dumper.
// Holds the FSM encoding, the frame sync byte and the default bit period.
package tensor_uart_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    HI,
    LO,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int DEFAULT_CLKS_PER_BIT = 217;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: load/data in, tx line and one-cycle done out.
// Ports: clock, reset_n, load, data[7:0] -> tx, done, active.
module uart_tx_byte
  import tensor_uart_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       active
);

  localparam logic [15:0] CNT_MAX =
    16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [8:0]  sh;
  logic        bit_end;

  assign bit_end = active && (cnt == CNT_MAX);
  // done marks the final cycle of the stop bit
  assign done = bit_end && (bit_idx == 4'd9);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else if (!active) begin
      if (load) begin
        active  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
        // stop bit rides in sh[8] and
        // falls out after the 8 data bits
        sh      <= {1'b1, data};
        tx      <= 1'b0;
      end
    end else if (bit_end) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        active  <= 1'b0;
        tx      <= 1'b1;
        bit_idx <= '0;
      end else begin
        tx      <= sh[0];
        sh      <= {1'b0, sh[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tensor_uart_dumper.sv
// Streams one tensor over UART: sync, hi/lo element bytes, XOR checksum.
// Ports: clock, reset_n, start, data[15:0] -> read_tensor_id, read_index, tx, busy.
module tensor_uart_dumper
  import tensor_uart_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TENSOR_ID    = 0,
  parameter int TENSOR_LEN   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic [15:0] read_tensor_id,
  output logic [15:0] read_index,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] LAST_IDX =
    16'(TENSOR_LEN - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] data_q;
  logic [7:0]  csum;
  logic        load;
  logic [7:0]  tx_byte;
  logic        done;
  logic        active;
  logic        last;

  assign read_tensor_id = 16'(TENSOR_ID);
  assign busy = (state != IDLE);
  assign last = (read_index == LAST_IDX);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (load),
    .data   (tx_byte),
    .tx     (tx),
    .done   (done),
    .active (active)
  );

  // Each byte is loaded in the single idle
  // cycle after the previous stop bit; the
  // hi byte is loaded straight from data in
  // FETCH so that cycle doubles as the gap.
  always_comb begin
    nxt     = state;
    load    = 1'b0;
    tx_byte = SYNC_BYTE;
    unique case (state)
      IDLE: begin
        if (start) nxt = SYNC;
      end
      SYNC: begin
        load = !active;
        if (done) nxt = FETCH;
      end
      FETCH: begin
        load    = 1'b1;
        tx_byte = data[15:8];
        nxt     = HI;
      end
      HI: begin
        if (done) nxt = LO;
      end
      LO: begin
        load    = !active;
        tx_byte = data_q[7:0];
        if (done) nxt = last ? CSUM : FETCH;
      end
      CSUM: begin
        load    = !active;
        tx_byte = csum;
        if (done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      csum       <= '0;
      read_index <= '0;
    end else begin
      if (state == IDLE && start) begin
        csum <= '0;
      end
      if (state == FETCH) begin
        data_q <= data;
        csum   <= csum ^ data[15:8];
      end
      if (state == LO && load) begin
        csum <= csum ^ data_q[7:0];
      end
      if (state == LO && done && !last) begin
        read_index <= read_index + 16'd1;
      end
      if (state == CSUM && done) begin
        read_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tensor_uart_dumper.sv
// Directed bench for tensor_uart_dumper with a UART-decoding scoreboard.
// Two DUTs: TENSOR_LEN=4 (matmul result) and TENSOR_LEN=1 (0xFF80).
module tb_tensor_uart_dumper;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start0, start1;
  logic [15:0] data0, data1;
  logic [15:0] tid0, tid1, idx0, idx1;
  logic        tx0, tx1, busy0, busy1;

  logic [15:0] mem [4] =
    '{16'h1600, 16'h1C00, 16'h3100, 16'h4000};

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign data0 = (tid0 == 16'd0 && idx0 < 16'd4)
               ? mem[idx0[1:0]] : 16'hDEAD;
  assign data1 = (tid1 == 16'd0 && idx1 == 16'd0)
               ? 16'hFF80 : 16'hDEAD;

  tensor_uart_dumper #(
    .CLKS_PER_BIT(CPB),
    .TENSOR_ID   (0),
    .TENSOR_LEN  (4)
  ) dut0 (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start0),
    .data          (data0),
    .read_tensor_id(tid0),
    .read_index    (idx0),
    .tx            (tx0),
    .busy          (busy0)
  );

  tensor_uart_dumper #(
    .CLKS_PER_BIT(CPB),
    .TENSOR_ID   (0),
    .TENSOR_LEN  (1)
  ) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start1),
    .data          (data1),
    .read_tensor_id(tid1),
    .read_index    (idx1),
    .tx            (tx1),
    .busy          (busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic txw(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busyw(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  // c0 = posedges seen when start is driven;
  // accept edge is c0+1, start bit from c0+2.
  task automatic push_frame(input int w,
                            input int c0);
    logic [7:0] bs[$];
    logic [7:0] x;
    logic [15:0] v;
    exp_t e;
    x = 8'h00;
    bs.push_back(8'hA5);
    for (int i = 0; i < ((w == 0) ? 4 : 1); i++) begin
      v = (w == 0) ? mem[i] : 16'hFF80;
      bs.push_back(v[15:8]);
      bs.push_back(v[7:0]);
      x = x ^ v[15:8] ^ v[7:0];
    end
    bs.push_back(x);
    for (int k = 0; k < bs.size(); k++) begin
      e.b = bs[k];
      e.t = c0 + 2 + 41 * k;
      if (w == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic pulse(input int w, input bit push);
    if (w == 0) start0 = 1'b1;
    else start1 = 1'b1;
    if (push) push_frame(w, cyc);
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int w,
                           output int n);
    n = 0;
    while (busyw(w) && n < 2000) begin
      n++;
      tick(1);
    end
  endtask

  // Decodes tx at mid-bit on negedges and
  // checks each byte and its start cycle.
  task automatic mon(input int w);
    logic [7:0] v;
    logic sb, pb;
    bit ok, got;
    int s;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && txw(w) === 1'b0) begin
        s  = cyc;
        ok = 1'b1;
        v  = 8'h00;
        repeat (2) @(negedge clock);
        sb = txw(w);
        if (reset_n !== 1'b1) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge clock);
          v[j] = txw(w);
          if (reset_n !== 1'b1) ok = 1'b0;
        end
        repeat (4) @(negedge clock);
        pb = txw(w);
        if (reset_n !== 1'b1) ok = 1'b0;
        if (ok) begin
          got = (w == 0) ? (q0.size() > 0)
                         : (q1.size() > 0);
          checks++;
          assert (got) else begin
            errors++;
            $error("FAIL extra_byte%0d: observed=%0h at cycle %0d expected=none",
                   w, v, s);
          end
          if (got) begin
            e = (w == 0) ? q0.pop_front()
                         : q1.pop_front();
            chk("byte", {24'h0, v}, {24'h0, e.b});
            chk("byte_time", s, e.t);
            chk("start_bit", {31'h0, sb}, 32'h0);
            chk("stop_bit", {31'h0, pb}, 32'h1);
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq[$];
    logic [15:0] last;
    int n;
    int tid_bad;

    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    tick(3);
    chk("rst_tx", {31'h0, tx0}, 32'h1);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_idx", {16'h0, idx0}, 32'h0);
    chk("rst_tid", {16'h0, tid0}, 32'h0);
    chk("rst_tx1", {31'h0, tx1}, 32'h1);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    reset_n = 1'b1;
    tick(3);

    // basic frame, busy length, index walk
    pulse(0, 1'b1);
    chk("busy_rise", {31'h0, busy0}, 32'h1);
    chk("idx_sync", {16'h0, idx0}, 32'h0);
    n = 0;
    tid_bad = 0;
    last = idx0;
    while (busy0 && n < 2000) begin
      if (idx0 !== last) begin
        seq.push_back(idx0);
        last = idx0;
      end
      if (tid0 !== 16'd0) tid_bad++;
      n++;
      tick(1);
    end
    if (idx0 !== last) seq.push_back(idx0);
    chk("busy_len", n, 410);
    chk("idx_changes", seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("idx_seq",
          (i < seq.size()) ? {16'h0, seq[i]} : 32'hFFFF_FFFF,
          (i + 1) % 4);
    end
    chk("tid_const", tid_bad, 0);
    tick(5);
    chk("drain1", q0.size(), 0);

    // second start mid-frame is ignored
    tick(3);
    pulse(0, 1'b1);
    tick(99);
    pulse(0, 1'b0);
    wait_idle(0, n);
    tick(60);
    chk("no_queue_busy", {31'h0, busy0}, 32'h0);
    chk("no_queue_tx", {31'h0, tx0}, 32'h1);
    chk("drain2", q0.size(), 0);

    // reset mid-frame aborts asynchronously
    tick(3);
    pulse(0, 1'b1);
    tick(149);
    reset_n = 1'b0;
    #1;
    chk("abort_tx", {31'h0, tx0}, 32'h1);
    chk("abort_busy", {31'h0, busy0}, 32'h0);
    chk("abort_idx", {16'h0, idx0}, 32'h0);
    q0.delete();
    tick(6);
    reset_n = 1'b1;
    tick(40);
    pulse(0, 1'b1);
    wait_idle(0, n);
    chk("post_rst_len", n, 410);
    tick(5);
    chk("drain3", q0.size(), 0);

    // start on the busy-fall cycle, then retry
    tick(3);
    pulse(0, 1'b1);
    tick(409);
    chk("busy_last", {31'h0, busy0}, 32'h1);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    chk("fall_ignored", {31'h0, busy0}, 32'h0);
    pulse(0, 1'b1);
    chk("restart", {31'h0, busy0}, 32'h1);
    wait_idle(0, n);
    chk("restart_len", n, 410);
    tick(5);
    chk("drain4", q0.size(), 0);

    // single-element tensor
    pulse(1, 1'b1);
    chk("len1_idx", {16'h0, idx1}, 32'h0);
    wait_idle(1, n);
    chk("len1_busy", n, 164);
    tick(5);
    chk("drain5", q1.size(), 0);
    chk("len1_idx_end", {16'h0, idx1}, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tensor_uart_dumper.md
TENSOR_UART_DUMPER -- requirements
Module: tensor_uart_dumper

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per UART bit (25 MHz / 115200).
REQ-002 SHALL have parameter TENSOR_ID, default 0, tensor id driven on read_tensor_id.
REQ-003 SHALL have parameter TENSOR_LEN, default 4, element count streamed per frame (1..65535).
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting a frame dump.
REQ-007 data  input  16  kernel read-port data (signed Q8.8), combinational function of read_tensor_id/read_index.
REQ-008 read_tensor_id  output  16  constant TENSOR_ID.
REQ-009 read_index  output  16  element index presented to kernel read port.
REQ-010 tx  output  1  UART 8N1 serial line, idle high.
REQ-011 busy  output  1  high while a frame is in progress.

Function
REQ-012 Frame SHALL be: sync byte 0xA5; per element i = 0..TENSOR_LEN-1, data[15:8] then data[7:0]; checksum byte = XOR of all element bytes (sync excluded).
REQ-013 Each byte SHALL be sent LSB first: start bit 0, 8 data bits, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-014 Consecutive bytes SHALL be separated by exactly 1 idle-high cycle; a frame lasts (2 + 2*TENSOR_LEN) * (10*CLKS_PER_BIT + 1) cycles, measured from the cycle after start.
REQ-015 FSM states: IDLE, SYNC, FETCH, HI, LO, CSUM; IDLE->SYNC on start; SYNC->FETCH; FETCH->HI; HI->LO; LO->FETCH (index+1) or CSUM (last element); CSUM->IDLE.
REQ-016 FETCH SHALL last exactly one cycle, with read_index stable; data SHALL be registered at the end of FETCH and never sampled in another state.
REQ-017 read_index SHALL be 0 in IDLE and SYNC, SHALL increment after LO completes, and SHALL return to 0 at frame end (no wrap beyond TENSOR_LEN-1).
REQ-018 Checksum register SHALL be cleared on frame start and XOR-updated with each element byte as that byte is loaded.
REQ-019 Start bit of the sync byte SHALL appear on tx the first clock edge after start is sampled high in IDLE.
REQ-020 start while busy SHALL be ignored, with no queuing.
REQ-021 busy SHALL rise on the edge that accepts start and fall on the edge that ends the checksum stop bit; start in that same cycle SHALL be ignored.
REQ-022 Bit-period counter SHALL be 16 bits wide; CLKS_PER_BIT < 2 is unsupported.

Reset
REQ-023 While reset_n is low: tx=1, busy=0, read_index=0, FSM=IDLE, counters and checksum=0, asynchronously.
REQ-024 Reset mid-frame SHALL abort the frame immediately; the next frame after release SHALL restart at the sync byte.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding, SYNC_BYTE=0xA5 and the default CLKS_PER_BIT.
REQ-026 Byte serialisation SHALL be one sub-module, uart_tx_byte: load/byte in, done pulse out, on the same clock and reset.

Verification (CLKS_PER_BIT=4, TENSOR_LEN=4, kernel model holding matmul result 0x1600, 0x1C00, 0x3100, 0x4000)
REQ-027 Start pulse -> tx decodes A5 16 00 1C 00 31 00 40 00 7B; busy high for exactly 10*41 = 410 cycles.
REQ-028 Start pulse -> read_index steps 0,1,2,3 and holds each value through its FETCH cycle; read_tensor_id = 0 throughout.
REQ-029 Second start pulse at cycle 100 of a frame -> frame is byte-identical to REQ-027 and no second frame follows.
REQ-030 reset_n low at cycle 150 -> tx=1 and busy=0 in the same cycle; after release, start produces a full frame from 0xA5.
REQ-031 Start pulse on the cycle busy falls -> ignored; a start one cycle later -> new frame begins on the next edge.
REQ-032 TENSOR_LEN=1, data=0xFF80 -> bytes A5 FF 80 7F.
